// File: rtl/lsu_wb_master_pkg.sv
// Shared width codes, FSM encoding and the request legality check for the LSU and its bus slaves.
// Pure declarations: no latency, no flow control.
package lsu_wb_master_pkg;

  localparam logic [2:0] WB_SEL_B  = 3'b000;
  localparam logic [2:0] WB_SEL_H  = 3'b001;
  localparam logic [2:0] WB_SEL_W  = 3'b010;
  localparam logic [2:0] WB_SEL_BU = 3'b100;
  localparam logic [2:0] WB_SEL_HU = 3'b101;

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_REQ      = 2'd1;
  localparam logic [1:0] S_WAIT_ACK = 2'd2;
  localparam logic [1:0] S_RESP     = 2'd3;

  // Illegal width code, or an address not naturally aligned to the access size.
  function automatic logic req_bad(input logic [2:0] funct3, input logic [1:0] addr_lo);
    case (funct3)
      WB_SEL_B, WB_SEL_BU: req_bad = 1'b0;
      WB_SEL_H, WB_SEL_HU: req_bad = addr_lo[0];
      WB_SEL_W:            req_bad = |addr_lo;
      default:             req_bad = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Sign/zero extension of load data by width code; purely combinational, no backpressure.
module lsu_load_extend
  import lsu_wb_master_pkg::*;
(
  input  logic [31:0] data,
  input  logic [2:0]  funct3,
  output logic [31:0] ext
);

  always_comb begin
    ext = data;
    case (funct3)
      WB_SEL_B:  ext = {{24{data[7]}}, data[7:0]};
      WB_SEL_H:  ext = {{16{data[15]}}, data[15:0]};
      WB_SEL_BU: ext = {24'd0, data[7:0]};
      WB_SEL_HU: ext = {16'd0, data[15:0]};
      default:   ext = data;
    endcase
  end

endmodule

// File: rtl/lsu_wb_master.sv
// Single-outstanding Wishbone master for core loads/stores; response 2 cycles after accept with no stall
// and same-cycle ack (1 for rejected requests); holds stb while stalled, bounded ack wait.
module lsu_wb_master
  import lsu_wb_master_pkg::*;
#(
  parameter int ACK_TIMEOUT = 255,
  parameter int TIMEOUT_W   = 16
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  input  logic        i_req_we,
  input  logic [2:0]  i_req_funct3,
  output logic        o_rsp_valid,
  output logic [31:0] o_rsp_data,
  output logic        o_rsp_err,
  output logic        o_wb_stb,
  output logic [31:0] o_wb_addr,
  output logic [31:0] o_wb_data,
  output logic        o_wb_we,
  output logic [2:0]  o_wb_sel,
  input  logic [31:0] i_wb_data,
  input  logic        i_wb_ack,
  input  logic        i_wb_stall
);

  localparam logic [TIMEOUT_W-1:0] TMO_LAST = TIMEOUT_W'(ACK_TIMEOUT - 1);
  localparam logic [TIMEOUT_W-1:0] TMO_ONE  = TIMEOUT_W'(1);

  logic [1:0]           state;
  logic [TIMEOUT_W-1:0] tmo_cnt;
  logic [31:0]          rdata;
  logic                 err;
  logic [31:0]          ext_data;

  // Handshake outputs decode straight from state so reset kills them asynchronously.
  assign o_req_ready = (state == S_IDLE);
  assign o_wb_stb    = (state == S_REQ);
  assign o_rsp_valid = (state == S_RESP);
  assign o_rsp_err   = err;
  assign o_rsp_data  = (err || o_wb_we) ? 32'd0 : ext_data;

  lsu_load_extend u_extend (
    .data   (rdata),
    .funct3 (o_wb_sel),
    .ext    (ext_data)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state     <= S_IDLE;
      tmo_cnt   <= '0;
      rdata     <= '0;
      err       <= 1'b0;
      o_wb_addr <= '0;
      o_wb_data <= '0;
      o_wb_we   <= 1'b0;
      o_wb_sel  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_req_valid) begin
            o_wb_addr <= i_req_addr;
            o_wb_data <= i_req_wdata;
            o_wb_we   <= i_req_we;
            o_wb_sel  <= i_req_funct3;
            if (req_bad(i_req_funct3, i_req_addr[1:0])) begin
              err   <= 1'b1;
              state <= S_RESP;
            end else begin
              state <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (!i_wb_stall) begin
            if (i_wb_ack) begin
              rdata <= i_wb_data;
              state <= S_RESP;
            end else begin
              tmo_cnt <= '0;
              state   <= S_WAIT_ACK;
            end
          end
        end
        S_WAIT_ACK: begin
          // Ack is checked first so an ack coinciding with expiry still succeeds.
          if (i_wb_ack) begin
            rdata <= i_wb_data;
            state <= S_RESP;
          end else if (tmo_cnt == TMO_LAST) begin
            rdata <= '0;
            err   <= 1'b1;
            state <= S_RESP;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_ONE;
          end
        end
        default: begin
          rdata <= '0;
          err   <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_wb_master.sv
// Randomised bench for lsu_wb_master against a transaction-level timing and data model.
module tb_lsu_wb_master;

  localparam int T = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        req_we = 1'b0;
  logic [2:0]  req_f3 = '0;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        wb_stb;
  logic [31:0] wb_addr;
  logic [31:0] wb_wdata;
  logic        wb_we;
  logic [2:0]  wb_sel;
  logic [31:0] wb_rdata = '0;
  logic        wb_ack = 1'b0;
  logic        wb_stall = 1'b0;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  lsu_wb_master #(.ACK_TIMEOUT(T), .TIMEOUT_W(16)) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_req_valid  (req_valid),
    .o_req_ready  (req_ready),
    .i_req_addr   (req_addr),
    .i_req_wdata  (req_wdata),
    .i_req_we     (req_we),
    .i_req_funct3 (req_f3),
    .o_rsp_valid  (rsp_valid),
    .o_rsp_data   (rsp_data),
    .o_rsp_err    (rsp_err),
    .o_wb_stb     (wb_stb),
    .o_wb_addr    (wb_addr),
    .o_wb_data    (wb_wdata),
    .o_wb_we      (wb_we),
    .o_wb_sel     (wb_sel),
    .i_wb_data    (wb_rdata),
    .i_wb_ack     (wb_ack),
    .i_wb_stall   (wb_stall)
  );

  // Reference model: legality and load extension from the width-code rules.
  function automatic bit ref_bad(input logic [2:0] f3, input logic [31:0] a);
    int sz;
    if (!(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b1;
    sz = 1 << f3[1:0];
    return (a % 32'(sz)) != 0;
  endfunction

  function automatic logic [31:0] ref_data(input logic [2:0] f3, input logic we, input logic [31:0] d);
    int v;
    if (we) return 32'd0;
    case (f3)
      3'd0: begin v = int'(d % 256);   if (v >= 128)   v -= 256;   end
      3'd1: begin v = int'(d % 65536); if (v >= 32768) v -= 65536; end
      3'd4: v = int'(d % 256);
      3'd5: v = int'(d % 65536);
      default: return d;
    endcase
    return 32'(v);
  endfunction

  // ack_dly: 0 = ack in the handshake cycle, k = ack k cycles later; > T means the slave never answers in time.
  task automatic run_txn(input string name, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic we, input logic [2:0] f3, input int stall_n, input int ack_dly,
                         input logic [31:0] rdata);
    bit bad, tmo, got, in_wait, fld_bad;
    int exp_lat, cyc, stb_cnt, hs_cnt, stall_left, wait_cnt, rsp_cyc;
    logic [31:0] exp_d, got_d;
    logic exp_e, got_e;
    bad = ref_bad(f3, addr);
    tmo = !bad && ack_dly > T;
    exp_e = bad || tmo;
    exp_d = exp_e ? 32'd0 : ref_data(f3, we, rdata);
    exp_lat = bad ? 1 : 1 + stall_n + (tmo ? T : ack_dly) + 1;

    @(negedge clk);
    compared++;
    if (req_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL %s ready_before_req: got %b want 1", name, req_ready);
    end
    req_valid = 1'b1; req_addr = addr; req_wdata = wdata; req_we = we; req_f3 = f3;
    @(negedge clk);
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_we = 1'($urandom); req_f3 = 3'($urandom);
    got = 0; in_wait = 0; fld_bad = 0; cyc = 1; stb_cnt = 0; hs_cnt = 0; wait_cnt = 0;
    stall_left = stall_n; rsp_cyc = 0; got_d = '0; got_e = 1'b0;
    while (!got && cyc <= 60) begin
      wb_stall = 1'b0; wb_ack = 1'b0; wb_rdata = $urandom;
      if (rsp_valid) begin
        got = 1; rsp_cyc = cyc; got_d = rsp_data; got_e = rsp_err;
        wb_ack = 1'($urandom);
      end else begin
        if (wb_stb) begin
          stb_cnt++;
          if (wb_addr !== addr || wb_wdata !== wdata || wb_we !== we || wb_sel !== f3) fld_bad = 1;
          if (stall_left > 0) begin
            wb_stall = 1'b1; stall_left--;
          end else begin
            hs_cnt++;
            if (ack_dly == 0) begin wb_ack = 1'b1; wb_rdata = rdata; end
            else in_wait = 1;
          end
        end else if (in_wait) begin
          wait_cnt++;
          if (wait_cnt == ack_dly) begin wb_ack = 1'b1; wb_rdata = rdata; end
        end
        @(negedge clk);
        cyc++;
      end
    end
    compared++;
    if (!got) begin
      mismatched++;
      $display("FAIL %s rsp_timeout: no rsp_valid within 60 cycles, want at +%0d", name, exp_lat);
    end else begin
      compared += 6;
      if (rsp_cyc != exp_lat) begin mismatched++; $display("FAIL %s latency: got %0d want %0d", name, rsp_cyc, exp_lat); end
      if (got_e !== exp_e) begin mismatched++; $display("FAIL %s err: got %b want %b", name, got_e, exp_e); end
      if (got_d !== exp_d) begin mismatched++; $display("FAIL %s data: got %h want %h", name, got_d, exp_d); end
      if (stb_cnt != (bad ? 0 : stall_n + 1)) begin mismatched++; $display("FAIL %s stb_cycles: got %0d want %0d", name, stb_cnt, bad ? 0 : stall_n + 1); end
      if (hs_cnt != (bad ? 0 : 1)) begin mismatched++; $display("FAIL %s handshakes: got %0d want %0d", name, hs_cnt, bad ? 0 : 1); end
      if (fld_bad) begin mismatched++; $display("FAIL %s wb_fields: got unstable/wrong want %h/%h/%b/%0d", name, addr, wdata, we, f3); end
      @(negedge clk);
      wb_ack = 1'b0;
      compared++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
        mismatched++;
        $display("FAIL %s after_rsp: got valid=%b ready=%b want valid=0 ready=1", name, rsp_valid, req_ready);
      end
    end
    wb_ack = 1'b0; wb_stall = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    compared++;
    if (wb_stb !== 1'b0 || rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_data !== 32'd0 ||
        wb_addr !== 32'd0 || wb_wdata !== 32'd0 || wb_sel !== 3'd0 || wb_we !== 1'b0 || req_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_state: got stb=%b v=%b e=%b d=%h a=%h w=%h s=%0d we=%b rdy=%b want all 0, ready 1",
               wb_stb, rsp_valid, rsp_err, rsp_data, wb_addr, wb_wdata, wb_sel, wb_we, req_ready);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_loads();
    run_txn("load_word", 32'h100, 32'h0, 1'b0, 3'b010, 0, 0, 32'h8001_00FF);
    run_txn("load_byte_s", 32'h101, 32'h0, 1'b0, 3'b000, 0, 0, 32'h0000_0080);
    run_txn("load_byte_u", 32'h101, 32'h0, 1'b0, 3'b100, 0, 0, 32'h0000_0080);
    run_txn("load_half_s", 32'h102, 32'h0, 1'b0, 3'b001, 0, 2, 32'h1234_9ABC);
    run_txn("load_half_u", 32'h102, 32'h0, 1'b0, 3'b101, 1, 1, 32'hFFFF_9ABC);
  endtask

  task automatic test_stall();
    run_txn("stall_store", 32'h20, 32'hDEAD_BEEF, 1'b1, 3'b010, 3, 0, 32'h5555_5555);
  endtask

  task automatic test_reject();
    run_txn("misalign_half", 32'h3, 32'h0, 1'b0, 3'b001, 0, 0, 32'h0);
    run_txn("misalign_word", 32'h2, 32'h0, 1'b1, 3'b010, 0, 0, 32'h0);
    run_txn("illegal_f3_3", 32'h0, 32'h0, 1'b0, 3'b011, 0, 0, 32'h0);
    run_txn("illegal_f3_7", 32'h8, 32'h0, 1'b1, 3'b111, 0, 0, 32'h0);
  endtask

  task automatic test_timeout();
    bit spur;
    run_txn("timeout", 32'h40, 32'h0, 1'b0, 3'b010, 0, T + 1, 32'hAAAA_AAAA);
    spur = 0;
    for (int i = 0; i < 3; i++) begin
      wb_ack = 1'b1; wb_rdata = 32'h1111_1111;
      @(negedge clk);
      if (rsp_valid !== 1'b0 || wb_stb !== 1'b0) spur = 1;
    end
    wb_ack = 1'b0;
    compared++;
    if (spur) begin mismatched++; $display("FAIL late_ack: got a response/strobe from a stray ack want none"); end
    run_txn("after_timeout", 32'h44, 32'h0, 1'b0, 3'b010, 0, 1, 32'hCAFE_F00D);
    run_txn("ack_at_limit", 32'h48, 32'h0, 1'b0, 3'b000, 0, T, 32'h0000_00FE);
  endtask

  task automatic test_reset_mid();
    bit spur;
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h80; req_we = 1'b0; req_f3 = 3'b010;
    @(negedge clk);
    req_valid = 1'b0;
    compared++;
    if (wb_stb !== 1'b1) begin mismatched++; $display("FAIL mid_stb: got %b want 1", wb_stb); end
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    compared++;
    if (wb_stb !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL mid_reset: got stb=%b v=%b rdy=%b want 0/0/1", wb_stb, rsp_valid, req_ready);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    wb_ack = 1'b1;
    spur = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      wb_ack = 1'b0;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || wb_stb !== 1'b0) spur = 1;
    end
    compared++;
    if (spur) begin mismatched++; $display("FAIL post_reset: got activity after reset want idle"); end
  endtask

  task automatic test_random();
    logic [2:0] f3;
    logic [31:0] a;
    for (int i = 0; i < 40; i++) begin
      f3 = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      run_txn("random", a, $urandom, 1'($urandom), f3, $urandom_range(0, 3),
              $urandom_range(0, T + 2), $urandom);
    end
  endtask

  initial begin
    test_reset();
    test_loads();
    test_stall();
    test_reject();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
